// File: rtl/retire_monitor.sv
`default_nettype none
// ============================================================================
// Module   : retire_monitor
// Purpose  : Retirement monitor for the RV32I core. Timestamps every retired
//            instruction into a show-ahead trace FIFO with a valid/ready
//            drain port, detects end of test (halt instruction, PC
//            no-progress, optional watchdog) and latches a pass/fail verdict
//            from the software error counter (x31).
// Config   : `RETMON_WATCHDOG_EN -- when defined, the run also ends when the
//            RUN cycle count reaches MAX_CYCLES (cause 2'b11).
// Ports    : clk_i, rst_n_i (async, active-high), en_i (start, IDLE only)
//            ret_valid_i / ret_pc_i / ret_instr_i  retire strobe and payload
//            err_cnt_i                             x31 error count tap
//            trc_valid_o / trc_ready_i             FIFO drain handshake
//            trc_pc_o / trc_instr_o / trc_cycle_o  FIFO head fields
//            ovf_o, drop_cnt_o                     overflow flag / drop count
//            cycle_cnt_o                           RUN cycles (saturating)
//            cause_o, done_o, pass_o               end cause, done, verdict
// Revision : 1.0 - initial release
// ============================================================================
module retire_monitor #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NP_LIMIT   = 256,
  parameter int unsigned MAX_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             ret_valid_i,
  input  logic [XLEN-1:0]  ret_pc_i,
  input  logic [31:0]      ret_instr_i,
  input  logic [XLEN-1:0]  err_cnt_i,
  output logic             trc_valid_o,
  input  logic             trc_ready_i,
  output logic [XLEN-1:0]  trc_pc_o,
  output logic [31:0]      trc_instr_o,
  output logic [CNT_W-1:0] trc_cycle_o,
  output logic             ovf_o,
  output logic [15:0]      drop_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [1:0]       cause_o,
  output logic             done_o,
  output logic             pass_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned NPW = $clog2(NP_LIMIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [NPW-1:0]   np_q, np_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             ovf_q;
  logic [15:0]      drop_q;
  logic [1:0]       cause_q, cause_d;
  logic             pass_q;
  logic             done_q;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [CNT_W-1:0] cyc_mem   [DEPTH];

  logic run, push_req, push, pop, full, drop;
  logic halt_hit, np_hit, wd_hit, end_run;

  assign run      = (state_q == S_RUN);
  assign push_req = run && ret_valid_i;
  assign pop      = (count_q != '0) && trc_ready_i;
  assign full     = (count_q == (AW+1)'(DEPTH));
  // At full, a same-cycle pop frees the slot the push needs.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    cycle_d   = cycle_q;
    last_pc_d = last_pc_q;
    np_d      = np_q;
    if (run) begin
      if (cycle_q != {CNT_W{1'b1}}) cycle_d = cycle_q + CNT_W'(1);
      if (ret_valid_i && (ret_pc_i != last_pc_q)) begin
        last_pc_d = ret_pc_i;
        np_d      = '0;
      end else begin
        np_d = np_q + NPW'(1);
      end
    end
  end

  assign halt_hit = ret_valid_i &&
                    ((ret_instr_i == 32'h0000_0073) || (ret_instr_i == 32'h0010_0073));
  assign np_hit   = (np_d == NPW'(NP_LIMIT));

`ifdef RETMON_WATCHDOG_EN
  // Compared against the incremented count so the run ends on the cycle
  // that brings cycle_cnt to MAX_CYCLES.
  assign wd_hit = (cycle_d == CNT_W'(MAX_CYCLES));
`else
  logic [CNT_W-1:0] unused_max_cycles;
  assign unused_max_cycles = CNT_W'(MAX_CYCLES);
  assign wd_hit = 1'b0;
`endif

  assign end_run = run && (halt_hit || np_hit || wd_hit);

  always_comb begin
    if (halt_hit)    cause_d = 2'b01;
    else if (np_hit) cause_d = 2'b10;
    else             cause_d = 2'b11;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en_i) state_d = S_RUN;
      S_RUN:   if (end_run) state_d = S_DRAIN;
      S_DRAIN: if (count_q == '0) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_q   <= S_IDLE;
      cycle_q   <= '0;
      last_pc_q <= '0;
      np_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
      cause_q   <= 2'b00;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      last_pc_q <= last_pc_d;
      np_q      <= np_d;
      done_q    <= (state_d == S_DONE);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
      // Cause and verdict are written only on the RUN->DRAIN edge.
      if (end_run) begin
        cause_q <= cause_d;
        pass_q  <= (err_cnt_i == '0);
      end
    end
  end

  // Storage carries no reset: pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= ret_pc_i;
      instr_mem[wr_ptr_q] <= ret_instr_i;
      cyc_mem[wr_ptr_q]   <= cycle_d;
    end
  end

  assign trc_valid_o = (count_q != '0);
  assign trc_pc_o    = pc_mem[rd_ptr_q];
  assign trc_instr_o = instr_mem[rd_ptr_q];
  assign trc_cycle_o = cyc_mem[rd_ptr_q];
  assign ovf_o       = ovf_q;
  assign drop_cnt_o  = drop_q;
  assign cycle_cnt_o = cycle_q;
  assign cause_o     = cause_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_retire_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_monitor
// Purpose  : Self-checking bench for retire_monitor: a queue-based reference
//            model compared every cycle, directed scenarios with literal
//            expectations, then randomized runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retire_monitor;

  localparam int XLEN       = 32;
  localparam int DEPTH      = 4;
  localparam int NP_LIMIT   = 8;
  localparam int MAX_CYCLES = 20;
  localparam int CNT_W      = 6;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef RETMON_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             en_i;
  logic             ret_valid_i;
  logic [XLEN-1:0]  ret_pc_i;
  logic [31:0]      ret_instr_i;
  logic [XLEN-1:0]  err_cnt_i;
  logic             trc_valid_o;
  logic             trc_ready_i;
  logic [XLEN-1:0]  trc_pc_o;
  logic [31:0]      trc_instr_o;
  logic [CNT_W-1:0] trc_cycle_o;
  logic             ovf_o;
  logic [15:0]      drop_cnt_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [1:0]       cause_o;
  logic             done_o;
  logic             pass_o;

  retire_monitor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NP_LIMIT(NP_LIMIT),
    .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i), .ret_instr_i(ret_instr_i),
    .err_cnt_i(err_cnt_i), .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i),
    .trc_pc_o(trc_pc_o), .trc_instr_o(trc_instr_o), .trc_cycle_o(trc_cycle_o),
    .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o), .cycle_cnt_o(cycle_cnt_o),
    .cause_o(cause_o), .done_o(done_o), .pass_o(pass_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  function automatic void chk(input string name, input longint unsigned act,
                              input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          cyc;
  } ent_t;

  ent_t        m_q[$];
  int          m_mode;   // 0 idle, 1 run, 2 drain, 3 done
  int          m_cyc, m_np, m_drop, m_cause;
  logic [31:0] m_last;
  bit          m_ovf, m_pass;

  always @(posedge clk_i or posedge rst_n_i) begin : model
    int pre_sz;
    bit pop, full;
    if (rst_n_i) begin
      m_q.delete();
      m_mode = 0; m_cyc = 0; m_np = 0; m_drop = 0; m_cause = 0;
      m_last = '0; m_ovf = 1'b0; m_pass = 1'b0;
    end else begin
      pre_sz = m_q.size();
      pop    = (pre_sz > 0) && trc_ready_i;
      full   = (pre_sz == DEPTH);
      if (pop) void'(m_q.pop_front());
      case (m_mode)
        0: if (en_i) m_mode = 1;
        1: begin
          if (m_cyc < CNT_MAX) m_cyc++;
          if (ret_valid_i) begin
            if (!full || pop) m_q.push_back('{ret_pc_i, ret_instr_i, m_cyc});
            else begin
              m_ovf = 1'b1;
              if (m_drop < 65535) m_drop++;
            end
          end
          if (ret_valid_i && ret_pc_i != m_last) begin
            m_last = ret_pc_i;
            m_np   = 0;
          end else begin
            m_np++;
          end
          if (ret_valid_i && (ret_instr_i == 32'h0000_0073 || ret_instr_i == 32'h0010_0073))
            m_cause = 1;
          else if (m_np == NP_LIMIT)
            m_cause = 2;
          else if (WD && m_cyc == MAX_CYCLES)
            m_cause = 3;
          if (m_cause != 0) begin
            m_mode = 2;
            m_pass = (err_cnt_i == 0);
          end
        end
        2: if (pre_sz == 0) m_mode = 3;
        default: ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("trc_valid", trc_valid_o, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("trc_pc", trc_pc_o, m_q[0].pc);
        chk("trc_instr", trc_instr_o, m_q[0].instr);
        chk("trc_cycle", trc_cycle_o, m_q[0].cyc);
      end
      chk("ovf", ovf_o, m_ovf);
      chk("drop_cnt", drop_cnt_o, m_drop);
      chk("cycle_cnt", cycle_cnt_o, m_cyc);
      chk("cause", cause_o, m_cause);
      chk("done", done_o, m_mode == 3);
      chk("pass", pass_o, m_pass);
    end
  end

  // Record accepted pops for the literal scenario checks.
  logic [31:0] pop_pc[$];
  int          pop_cyc[$];
  always @(posedge clk_i) begin
    if (!rst_n_i && trc_valid_o && trc_ready_i) begin
      pop_pc.push_back(trc_pc_o);
      pop_cyc.push_back(int'(trc_cycle_o));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Every helper starts and ends at a falling edge.
  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit rdy, input logic [31:0] err);
    #1;
    en_i = 1'b0; ret_valid_i = v; ret_pc_i = pc; ret_instr_i = ins;
    trc_ready_i = rdy; err_cnt_i = err;
    @(negedge clk_i);
  endtask

  task automatic start();
    #1;
    en_i = 1'b1; ret_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    #1;
    rst_n_i = 1'b1; en_i = 1'b0; ret_valid_i = 1'b0; ret_pc_i = '0;
    ret_instr_i = NOP; trc_ready_i = 1'b0; err_cnt_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    rst_n_i = 1'b0;
    pop_pc.delete();
    pop_cyc.delete();
    @(negedge clk_i);
  endtask

  task automatic halt_program(input logic [31:0] err);
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'(i * 4), (i == 4) ? ECALL : NOP, 1'b1, err);
  endtask

  initial begin
    rst_n_i = 1'b1; en_i = 1'b0; ret_valid_i = 1'b0; ret_pc_i = '0;
    ret_instr_i = NOP; trc_ready_i = 1'b0; err_cnt_i = '0;
    @(negedge clk_i);
    do_reset();
    chk_en = 1'b1;

    // Reset values
    chk("rst_valid", trc_valid_o, 0);
    chk("rst_cause", cause_o, 0);
    chk("rst_cycle", cycle_cnt_o, 0);
    chk("rst_done", done_o, 0);

    // Normal halt
    start();
    halt_program(32'd0);
    chk("halt_cause", cause_o, 2'b01);
    chk("halt_pass", pass_o, 1);
    repeat (4) drive(1'b0, '0, NOP, 1'b1, 32'd0);
    chk("halt_done", done_o, 1);
    chk("halt_npop", pop_pc.size(), 5);
    for (int i = 0; i < 5 && i < pop_pc.size(); i++) begin
      chk("halt_pop_pc", pop_pc[i], 32'(i * 4));
      chk("halt_pop_cyc", pop_cyc[i], i + 1);
    end

    // Failing verdict
    do_reset();
    start();
    halt_program(32'd3);
    chk("fail_cause", cause_o, 2'b01);
    chk("fail_pass", pass_o, 0);

    // Overflow at DEPTH=4
    do_reset();
    start();
    for (int i = 0; i < 6; i++) drive(1'b1, 32'h100 + 32'(i * 4), NOP, 1'b0, 32'd0);
    chk("ovf_flag", ovf_o, 1);
    chk("ovf_drops", drop_cnt_o, 2);
    repeat (6) drive(1'b0, '0, NOP, 1'b1, 32'd0);
    chk("ovf_npop", pop_pc.size(), 4);
    for (int i = 0; i < 4 && i < pop_pc.size(); i++)
      chk("ovf_pop_pc", pop_pc[i], 32'h100 + 32'(i * 4));

    // Reset mid-operation, then full FIFO with simultaneous push and pop
    do_reset();
    chk("rst2_valid", trc_valid_o, 0);
    chk("rst2_ovf", ovf_o, 0);
    chk("rst2_drop", drop_cnt_o, 0);
    start();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h200 + 32'(i * 4), NOP, 1'b0, 32'd0);
    drive(1'b1, 32'h210, NOP, 1'b1, 32'd0);
    chk("full_drop", drop_cnt_o, 0);
    chk("full_ovf", ovf_o, 0);
    repeat (5) drive(1'b0, '0, NOP, 1'b1, 32'd0);
    chk("full_npop", pop_pc.size(), 5);
    if (pop_pc.size() == 5) begin
      chk("full_first", pop_pc[0], 32'h200);
      chk("full_last", pop_pc[4], 32'h210);
    end

    // No-progress
    do_reset();
    start();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h40, NOP, 1'b1, 32'd0);
    chk("np_before", cause_o, 0);
    drive(1'b1, 32'h40, NOP, 1'b1, 32'd0);
    chk("np_cause", cause_o, 2'b10);

    // Watchdog / saturation
    do_reset();
    start();
    for (int i = 0; i < 25; i++) drive(1'b1, 32'h1000 + 32'(i * 4), NOP, 1'b1, 32'd0);
`ifdef RETMON_WATCHDOG_EN
    chk("wd_cause", cause_o, 2'b11);
    chk("wd_cycle", cycle_cnt_o, 20);
`else
    chk("nowd_cause", cause_o, 0);
    chk("nowd_cycle_gt", cycle_cnt_o > 20, 1);
    for (int i = 25; i < 70; i++) drive(1'b1, 32'h1000 + 32'(i * 4), NOP, 1'b1, 32'd0);
    chk("nowd_sat", cycle_cnt_o, CNT_MAX);
`endif

    // Randomized runs, checked by the model every cycle
    for (int r = 0; r < 20; r++) begin
      int rdy_pct;
      do_reset();
      start();
      rdy_pct = $urandom_range(10, 100);
      for (int c = 0; c < 60; c++) begin
        logic [31:0] ins;
        ins = NOP;
        if ($urandom_range(0, 29) == 0) ins = $urandom_range(0, 1) ? 32'h0010_0073 : ECALL;
        else if ($urandom_range(0, 9) == 0) ins = $urandom;
        drive($urandom_range(0, 1) == 1, 32'($urandom_range(0, 3) * 4), ins,
              $urandom_range(1, 100) <= rdy_pct, 32'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
